dram_init_compliance_checker: RTL and testbench
===============================================

DRAM_INIT_COMPLIANCE_CHECKER -- requirements
Module: dram_init_compliance_checker

Interface
REQ-001 The block SHALL have parameters (name, default, meaning), one per line:
- T_PWR, 200000, minimum cycles with dram_power_rst_n low.
- T_RST, 500000, minimum consecutive CMD_RESET cycles.
- T_XPR, 243, minimum NOP cycles before the first MRS.
- T_MRD, 4, minimum NOP cycles between MRS commands.
- T_MOD, 12, minimum NOP cycles from the last MRS to ZQCAL.
- T_ZQINIT, 512, NOP cycles after ZQCAL before ready.
- NUM_MRS, 4, MRS commands required.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- dram_power_rst_n, in, 1, device power/reset pin.
- command_i, in, command_t, command sampled every cycle.
- device_ready_o, out, 1, initialization completed legally.
- violation_o, out, 1, sticky protocol violation.
- violation_code_o, out, 3, first violation cause.
- mrs_count_o, out, 3, accepted MRS count.
- dev_state_o, out, dev_state_t, current device state.

REQ-003 Reset SHALL be rst_n, asynchronous, active-low; clock SHALL be clk.

Function
REQ-004 All outputs SHALL be registered and SHALL reflect an input sampled at edge N at edge N+1.
REQ-005 States SHALL be DEV_OFF, DEV_RESET, DEV_WAIT_TXPR, DEV_MRS, DEV_WAIT_TMOD, DEV_ZQ, DEV_READY and DEV_ERROR.
REQ-006 A 20-bit cycle counter SHALL saturate at all-ones and SHALL be cleared on every state change or accepted MRS.
REQ-007 DEV_OFF SHALL count cycles while dram_power_rst_n is 0.
- When dram_power_rst_n is sampled 1: go to DEV_RESET if count >= T_PWR; otherwise raise code 1 (PWR_SHORT).
REQ-008 DEV_RESET SHALL count CMD_RESET cycles, with CMD_POWER_UP tolerated and not counted.
- On CMD_NOP: go to DEV_WAIT_TXPR if count >= T_RST; otherwise raise code 2 (RST_SHORT).
REQ-009 DEV_WAIT_TXPR SHALL count CMD_NOP cycles.
- On CMD_MRS: go to DEV_MRS with mrs_count=1 if count >= T_XPR; otherwise raise code 3 (TXPR).
REQ-010 DEV_MRS SHALL count CMD_NOP cycles.
- On CMD_MRS: accept and increment mrs_count if count >= T_MRD; otherwise raise code 4 (TMRD).
- The accepted MRS that makes mrs_count == NUM_MRS SHALL move the state to DEV_WAIT_TMOD.
REQ-011 DEV_WAIT_TMOD SHALL count CMD_NOP cycles.
- On CMD_ZQCAL: go to DEV_ZQ if count >= T_MOD; otherwise raise code 5 (TMOD).
REQ-012 DEV_ZQ SHALL count CMD_NOP cycles and SHALL move to DEV_READY when count reaches T_ZQINIT.
- Any non-NOP command before then SHALL raise code 6 (TZQ).
REQ-013 In DEV_READY, device_ready_o SHALL be 1 and every command SHALL be accepted without checking.
REQ-014 Any command not listed as legal for the current state SHALL raise code 7 (ILLEGAL_CMD).
- Timing codes 1-6 SHALL take priority over code 7 when the command is the expected one.
REQ-015 Raising a violation SHALL set violation_o=1, latch the code, and enter DEV_ERROR.
- Only the first code SHALL be kept; DEV_ERROR SHALL hold until rst_n.
REQ-016 dram_power_rst_n sampled 0 in any state except DEV_OFF or DEV_ERROR SHALL:
- go to DEV_OFF;
- clear the counter, mrs_count and device_ready_o;
- not count as a violation.
- This takes priority over all command checks in the same cycle.
REQ-017 mrs_count_o SHALL saturate at NUM_MRS.

Reset
REQ-018 On rst_n low:
- state SHALL be DEV_OFF;
- the counter SHALL be 0;
- device_ready_o, violation_o, violation_code_o and mrs_count_o SHALL be 0.
REQ-019 Assertion of rst_n mid-sequence SHALL discard all progress and any latched violation.

Structure
REQ-020 dev_state_t and violation_code_t (values 0-7) SHALL live in a new shared package, dram_device_state_pkg.
- command_t SHALL come from command_definition_pkg.
- Timing defaults SHALL be parameters, not package constants.
REQ-021 One sub-module, sat_cycle_counter, SHALL implement the 20-bit saturating counter with clear and enable.

Verification
Parameters for all scenarios: T_PWR=20, T_RST=50, T_XPR=10, T_MRD=4, T_MOD=12, T_ZQINIT=16, NUM_MRS=4.
REQ-022 Legal sequence (20 power-low cycles, 50 RESET, 10 NOP, 4 MRS each separated by 4 NOP, 12 NOP, ZQCAL, 16 NOP) -> device_ready_o=1 one cycle after the 16th NOP; violation_o=0; mrs_count_o=4.
REQ-023 Power pin released after 19 cycles -> violation_o=1, code=1, dev_state_o=DEV_ERROR on the next edge.
REQ-024 Second MRS after only 3 NOPs -> code=4; mrs_count_o stays 1.
REQ-025 CMD_ZQCAL issued during DEV_WAIT_TXPR -> code=7.
- A second violation afterwards -> code remains 7.
REQ-026 dram_power_rst_n dropped for 1 cycle while in DEV_MRS -> DEV_OFF, mrs_count_o=0, violation_o=0.
- A full legal sequence afterwards -> ready.
REQ-027 rst_n asserted while in DEV_ERROR -> all outputs 0 and DEV_OFF, asynchronously.

Source files
------------

// File: rtl/command_definition_pkg.sv
// Command encoding shared by the DRAM controller and its checkers.
package command_definition_pkg;

   typedef enum logic [2:0] {
      CMD_NOP      = 3'd0,
      CMD_RESET    = 3'd1,
      CMD_POWER_UP = 3'd2,
      CMD_MRS      = 3'd3,
      CMD_ZQCAL    = 3'd4,
      CMD_ACTIVATE = 3'd5,
      CMD_READ     = 3'd6,
      CMD_WRITE    = 3'd7
   } command_t;

endpackage : command_definition_pkg

// File: rtl/dram_device_state_pkg.sv
// Device-state and violation-code types for the DRAM initialization checker.
package dram_device_state_pkg;

   typedef enum logic [2:0] {
      DEV_OFF       = 3'd0,
      DEV_RESET     = 3'd1,
      DEV_WAIT_TXPR = 3'd2,
      DEV_MRS       = 3'd3,
      DEV_WAIT_TMOD = 3'd4,
      DEV_ZQ        = 3'd5,
      DEV_READY     = 3'd6,
      DEV_ERROR     = 3'd7
   } dev_state_t;

   typedef enum logic [2:0] {
      VIO_NONE        = 3'd0,
      VIO_PWR_SHORT   = 3'd1,
      VIO_RST_SHORT   = 3'd2,
      VIO_TXPR        = 3'd3,
      VIO_TMRD        = 3'd4,
      VIO_TMOD        = 3'd5,
      VIO_TZQ         = 3'd6,
      VIO_ILLEGAL_CMD = 3'd7
   } violation_code_t;

endpackage : dram_device_state_pkg

// File: rtl/sat_cycle_counter.sv
// Up-counter that sticks at all-ones; clear wins over enable.
module sat_cycle_counter #(
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   // Count register: clear, else increment until saturated.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule : sat_cycle_counter

// File: rtl/dram_init_compliance_checker.sv
// Watches the DRAM power pin and command bus and checks the initialization
// sequence (power, reset, tXPR, MRS spacing, tMOD, ZQ init) for legality.
module dram_init_compliance_checker
   import command_definition_pkg::*;
   import dram_device_state_pkg::*;
#(
   parameter int T_PWR    = 200000,
   parameter int T_RST    = 500000,
   parameter int T_XPR    = 243,
   parameter int T_MRD    = 4,
   parameter int T_MOD    = 12,
   parameter int T_ZQINIT = 512,
   parameter int NUM_MRS  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dram_power_rst_n,
   input  command_t   command_i,
   output logic       device_ready_o,
   output logic       violation_o,
   output logic [2:0] violation_code_o,
   output logic [2:0] mrs_count_o,
   output dev_state_t dev_state_o
);

   localparam int CW = 20;

   // Timing thresholds resized to the counter width for unsigned compares.
   localparam logic [CW-1:0] PWR_MIN  = CW'(T_PWR);
   localparam logic [CW-1:0] RST_MIN  = CW'(T_RST);
   localparam logic [CW-1:0] XPR_MIN  = CW'(T_XPR);
   localparam logic [CW-1:0] MRD_MIN  = CW'(T_MRD);
   localparam logic [CW-1:0] MOD_MIN  = CW'(T_MOD);
   localparam logic [CW:0]   ZQ_DONE  = (CW+1)'(T_ZQINIT);
   localparam logic [2:0]    MRS_LAST = 3'(NUM_MRS);

   dev_state_t      state_q, state_next;
   logic [2:0]      mrs_q, mrs_next;
   logic            ready_q, ready_next;
   logic            viol_q, viol_next;
   violation_code_t code_q, code_next;

   logic            cnt_clr, cnt_en;
   logic [CW-1:0]   cnt_q;
   logic            mrs_accept;
   logic            raise;
   violation_code_t raise_code;

   sat_cycle_counter #(
      .WIDTH (CW)
   ) u_cycle_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .count (cnt_q)
   );

   // Next-state, counter control and violation detection.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_next = state_q;
      mrs_next   = mrs_q;
      ready_next = ready_q;
      viol_next  = viol_q;
      code_next  = code_q;
      cnt_en     = 1'b0;
      mrs_accept = 1'b0;
      raise      = 1'b0;
      raise_code = VIO_NONE;

      if (!dram_power_rst_n && (state_q != DEV_OFF) && (state_q != DEV_ERROR)) begin
         // Power pin dropped mid-sequence: restart quietly, not a violation.
         state_next = DEV_OFF;
         mrs_next   = '0;
         ready_next = 1'b0;
      end else begin
         case (state_q)
            DEV_OFF: begin
               if (!dram_power_rst_n) begin
                  cnt_en = 1'b1;
               end else if (cnt_q >= PWR_MIN) begin
                  state_next = DEV_RESET;
               end else begin
                  raise      = 1'b1;
                  raise_code = VIO_PWR_SHORT;
               end
            end

            DEV_RESET: begin
               case (command_i)
                  CMD_RESET:    cnt_en = 1'b1;
                  CMD_POWER_UP: ;
                  CMD_NOP: begin
                     if (cnt_q >= RST_MIN) begin
                        state_next = DEV_WAIT_TXPR;
                     end else begin
                        raise      = 1'b1;
                        raise_code = VIO_RST_SHORT;
                     end
                  end
                  default: begin
                     raise      = 1'b1;
                     raise_code = VIO_ILLEGAL_CMD;
                  end
               endcase
            end

            DEV_WAIT_TXPR: begin
               case (command_i)
                  CMD_NOP: cnt_en = 1'b1;
                  CMD_MRS: begin
                     if (cnt_q >= XPR_MIN) begin
                        mrs_next   = 3'd1;
                        state_next = (MRS_LAST <= 3'd1) ? DEV_WAIT_TMOD : DEV_MRS;
                     end else begin
                        raise      = 1'b1;
                        raise_code = VIO_TXPR;
                     end
                  end
                  default: begin
                     raise      = 1'b1;
                     raise_code = VIO_ILLEGAL_CMD;
                  end
               endcase
            end

            DEV_MRS: begin
               case (command_i)
                  CMD_NOP: cnt_en = 1'b1;
                  CMD_MRS: begin
                     if (cnt_q >= MRD_MIN) begin
                        mrs_accept = 1'b1;
                        if ((mrs_q + 3'd1) >= MRS_LAST) begin
                           mrs_next   = MRS_LAST;
                           state_next = DEV_WAIT_TMOD;
                        end else begin
                           mrs_next = mrs_q + 3'd1;
                        end
                     end else begin
                        raise      = 1'b1;
                        raise_code = VIO_TMRD;
                     end
                  end
                  default: begin
                     raise      = 1'b1;
                     raise_code = VIO_ILLEGAL_CMD;
                  end
               endcase
            end

            DEV_WAIT_TMOD: begin
               case (command_i)
                  CMD_NOP: cnt_en = 1'b1;
                  CMD_ZQCAL: begin
                     if (cnt_q >= MOD_MIN) begin
                        state_next = DEV_ZQ;
                     end else begin
                        raise      = 1'b1;
                        raise_code = VIO_TMOD;
                     end
                  end
                  default: begin
                     raise      = 1'b1;
                     raise_code = VIO_ILLEGAL_CMD;
                  end
               endcase
            end

            DEV_ZQ: begin
               if (command_i == CMD_NOP) begin
                  cnt_en = 1'b1;
                  // The NOP that brings the count to T_ZQINIT completes init.
                  if (({1'b0, cnt_q} + 1'b1) >= ZQ_DONE) begin
                     state_next = DEV_READY;
                     ready_next = 1'b1;
                  end
               end else begin
                  raise      = 1'b1;
                  raise_code = VIO_TZQ;
               end
            end

            DEV_READY: ;
            DEV_ERROR: ;
            default: ;
         endcase
      end

      if (raise) begin
         state_next = DEV_ERROR;
         viol_next  = 1'b1;
         code_next  = raise_code;
         ready_next = 1'b0;
      end

      cnt_clr = (state_next != state_q) || mrs_accept;
   end

   // Registered state and outputs; rst_n discards all progress and violations.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DEV_OFF;
         mrs_q   <= '0;
         ready_q <= 1'b0;
         viol_q  <= 1'b0;
         code_q  <= VIO_NONE;
      end else begin
         state_q <= state_next;
         mrs_q   <= mrs_next;
         ready_q <= ready_next;
         viol_q  <= viol_next;
         code_q  <= code_next;
      end
   end

   assign device_ready_o   = ready_q;
   assign violation_o      = viol_q;
   assign violation_code_o = code_q;
   assign mrs_count_o      = mrs_q;
   assign dev_state_o      = state_q;

endmodule : dram_init_compliance_checker

// File: tb/tb_dram_init_compliance_checker.sv
// Directed bench for dram_init_compliance_checker with shortened timings.
module tb_dram_init_compliance_checker;
   import command_definition_pkg::*;
   import dram_device_state_pkg::*;

   localparam int T_PWR    = 20;
   localparam int T_RST    = 50;
   localparam int T_XPR    = 10;
   localparam int T_MRD    = 4;
   localparam int T_MOD    = 12;
   localparam int T_ZQINIT = 16;
   localparam int NUM_MRS  = 4;

   logic       clk;
   logic       rst_n;
   logic       dram_power_rst_n;
   command_t   command_i;
   logic       device_ready_o;
   logic       violation_o;
   logic [2:0] violation_code_o;
   logic [2:0] mrs_count_o;
   dev_state_t dev_state_o;

   int n_cmp;
   int n_err;

   dram_init_compliance_checker #(
      .T_PWR    (T_PWR),
      .T_RST    (T_RST),
      .T_XPR    (T_XPR),
      .T_MRD    (T_MRD),
      .T_MOD    (T_MOD),
      .T_ZQINIT (T_ZQINIT),
      .NUM_MRS  (NUM_MRS)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .dram_power_rst_n (dram_power_rst_n),
      .command_i        (command_i),
      .device_ready_o   (device_ready_o),
      .violation_o      (violation_o),
      .violation_code_o (violation_code_o),
      .mrs_count_o      (mrs_count_o),
      .dev_state_o      (dev_state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Apply cmd/pin for n edges; outputs are read 1 ns after the last edge.
   task automatic drive(input command_t cmd, input logic pwr, input int n);
      for (int i = 0; i < n; i++) begin
         command_i        = cmd;
         dram_power_rst_n = pwr;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n            = 1'b0;
      dram_power_rst_n = 1'b0;
      command_i        = CMD_NOP;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Legal sequence pieces; each leaves the DUT in the named state.
   task automatic to_reset_state();
      drive(CMD_NOP, 1'b0, T_PWR);
      drive(CMD_POWER_UP, 1'b1, 1);
   endtask

   task automatic to_txpr();
      drive(CMD_RESET, 1'b1, T_RST);
      drive(CMD_NOP, 1'b1, 1);
   endtask

   task automatic to_mrs();
      drive(CMD_NOP, 1'b1, T_XPR);
      drive(CMD_MRS, 1'b1, 1);
   endtask

   task automatic to_tmod();
      for (int k = 1; k < NUM_MRS; k++) begin
         drive(CMD_NOP, 1'b1, T_MRD);
         drive(CMD_MRS, 1'b1, 1);
      end
   endtask

   task automatic to_zq();
      drive(CMD_NOP, 1'b1, T_MOD);
      drive(CMD_ZQCAL, 1'b1, 1);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;

      // Reset values.
      do_reset();
      check("rst_state", dev_state_o, DEV_OFF);
      check("rst_ready", device_ready_o, 0);
      check("rst_viol", violation_o, 0);
      check("rst_code", violation_code_o, 0);
      check("rst_mrs", mrs_count_o, 0);

      // Full legal initialization.
      to_reset_state();
      check("leg_reset_state", dev_state_o, DEV_RESET);
      to_txpr();
      check("leg_txpr_state", dev_state_o, DEV_WAIT_TXPR);
      to_mrs();
      check("leg_mrs_state", dev_state_o, DEV_MRS);
      check("leg_mrs1", mrs_count_o, 1);
      drive(CMD_NOP, 1'b1, T_MRD);
      drive(CMD_MRS, 1'b1, 1);
      check("leg_mrs2", mrs_count_o, 2);
      drive(CMD_NOP, 1'b1, T_MRD);
      drive(CMD_MRS, 1'b1, 1);
      drive(CMD_NOP, 1'b1, T_MRD);
      drive(CMD_MRS, 1'b1, 1);
      check("leg_tmod_state", dev_state_o, DEV_WAIT_TMOD);
      check("leg_mrs4", mrs_count_o, 4);
      to_zq();
      check("leg_zq_state", dev_state_o, DEV_ZQ);
      drive(CMD_NOP, 1'b1, T_ZQINIT - 1);
      check("leg_not_ready_yet", device_ready_o, 0);
      drive(CMD_NOP, 1'b1, 1);
      check("leg_ready", device_ready_o, 1);
      check("leg_ready_state", dev_state_o, DEV_READY);
      check("leg_viol", violation_o, 0);
      check("leg_mrs_final", mrs_count_o, 4);
      drive(CMD_WRITE, 1'b1, 1);
      check("ready_any_cmd", dev_state_o, DEV_READY);
      drive(CMD_NOP, 1'b0, 1);
      check("ready_pwr_drop_state", dev_state_o, DEV_OFF);
      check("ready_pwr_drop_ready", device_ready_o, 0);

      // Power pin released one cycle early.
      do_reset();
      drive(CMD_NOP, 1'b0, T_PWR - 1);
      drive(CMD_POWER_UP, 1'b1, 1);
      check("pwr_short_viol", violation_o, 1);
      check("pwr_short_code", violation_code_o, VIO_PWR_SHORT);
      check("pwr_short_state", dev_state_o, DEV_ERROR);

      // One RESET cycle short.
      do_reset();
      to_reset_state();
      drive(CMD_RESET, 1'b1, T_RST - 1);
      drive(CMD_NOP, 1'b1, 1);
      check("rst_short_code", violation_code_o, VIO_RST_SHORT);

      // MRS one NOP too early after reset exit.
      do_reset();
      to_reset_state();
      to_txpr();
      drive(CMD_NOP, 1'b1, T_XPR - 1);
      drive(CMD_MRS, 1'b1, 1);
      check("txpr_short_code", violation_code_o, VIO_TXPR);

      // Second MRS after only 3 NOPs.
      do_reset();
      to_reset_state();
      to_txpr();
      to_mrs();
      drive(CMD_NOP, 1'b1, T_MRD - 1);
      drive(CMD_MRS, 1'b1, 1);
      check("tmrd_code", violation_code_o, VIO_TMRD);
      check("tmrd_mrs_held", mrs_count_o, 1);
      check("tmrd_state", dev_state_o, DEV_ERROR);

      // ZQCAL one NOP too early after the last MRS.
      do_reset();
      to_reset_state();
      to_txpr();
      to_mrs();
      to_tmod();
      drive(CMD_NOP, 1'b1, T_MOD - 1);
      drive(CMD_ZQCAL, 1'b1, 1);
      check("tmod_code", violation_code_o, VIO_TMOD);

      // Non-NOP during ZQ init.
      do_reset();
      to_reset_state();
      to_txpr();
      to_mrs();
      to_tmod();
      to_zq();
      drive(CMD_NOP, 1'b1, 5);
      drive(CMD_READ, 1'b1, 1);
      check("tzq_code", violation_code_o, VIO_TZQ);
      check("tzq_ready", device_ready_o, 0);

      // ZQCAL in WAIT_TXPR is illegal; later violations do not overwrite.
      do_reset();
      to_reset_state();
      to_txpr();
      drive(CMD_NOP, 1'b1, 2);
      drive(CMD_ZQCAL, 1'b1, 1);
      check("illegal_code", violation_code_o, VIO_ILLEGAL_CMD);
      drive(CMD_MRS, 1'b1, 1);
      drive(CMD_NOP, 1'b0, 2);
      check("illegal_code_kept", violation_code_o, VIO_ILLEGAL_CMD);
      check("illegal_state_kept", dev_state_o, DEV_ERROR);

      // Asynchronous reset out of DEV_ERROR, mid-cycle.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_state", dev_state_o, DEV_OFF);
      check("async_viol", violation_o, 0);
      check("async_code", violation_code_o, 0);
      check("async_mrs", mrs_count_o, 0);
      check("async_ready", device_ready_o, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Power dropped for one cycle in DEV_MRS, then a full legal sequence.
      dram_power_rst_n = 1'b0;
      command_i        = CMD_NOP;
      to_reset_state();
      to_txpr();
      to_mrs();
      drive(CMD_NOP, 1'b1, T_MRD);
      drive(CMD_MRS, 1'b1, 1);
      check("drop_pre_mrs", mrs_count_o, 2);
      drive(CMD_NOP, 1'b0, 1);
      check("drop_state", dev_state_o, DEV_OFF);
      check("drop_mrs", mrs_count_o, 0);
      check("drop_viol", violation_o, 0);
      to_reset_state();
      to_txpr();
      to_mrs();
      to_tmod();
      to_zq();
      drive(CMD_NOP, 1'b1, T_ZQINIT);
      check("drop_reinit_ready", device_ready_o, 1);
      check("drop_reinit_viol", violation_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_dram_init_compliance_checker
